// File: rtl/conv_pkg.sv
// Shared types and helpers for the KxK 2-D convolution window engine:
// FSM state encoding, stride decode constant and accumulator width rule.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_KER = 3'd1,
        LOAD_WIN = 3'd2,
        EMIT     = 3'd3,
        DONE     = 3'd4
    } state_t;

    // Only this i_stride encoding selects stride 2; everything else is stride 1.
    localparam logic [1:0] STRIDE_2 = 2'd2;

    // Product width plus enough headroom to sum K*K products without overflow.
    function automatic int acc_width(input int data_w, input int k);
        return 2 * data_w + $clog2(k * k);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// A single registered accumulator holds the running window sum.
module conv_mac #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_clr,
    input  logic                     i_en,
    input  logic signed [DATA_W-1:0] i_a,
    input  logic signed [DATA_W-1:0] i_b,
    output logic signed [ACC_W-1:0]  o_acc
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_q;

    assign prod  = i_a * i_b;
    assign o_acc = acc_q;

    // Clear wins over enable so a window always starts from zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
        end else if (i_clr) begin
            acc_q <= '0;
        end else if (i_en) begin
            acc_q <= acc_q + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/conv2d_window_engine.sv
// KxK sliding-window convolution engine: fetches the kernel, walks the frame at
// stride 1 or 2 and streams one signed sum per window. Optional ReLU: CONV_RELU_EN.
module conv2d_window_engine
    import conv_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int K      = 3,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 16,
    parameter int ACC_W  = acc_width(DATA_W, K)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic [1:0]               i_stride,
    input  logic [ADDR_W-1:0]        i_src_base,
    input  logic [ADDR_W-1:0]        i_ker_base,
    output logic                     o_src_rd,
    output logic [ADDR_W-1:0]        o_src_addr,
    input  logic signed [DATA_W-1:0] i_src_data,
    output logic                     o_ker_rd,
    output logic [ADDR_W-1:0]        o_ker_addr,
    input  logic signed [DATA_W-1:0] i_ker_data,
    output logic signed [ACC_W-1:0]  o_out_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic                     o_busy,
    output logic                     o_done,
    output state_t                   o_dbg_state
);

    localparam int TAPS     = K * K;
    localparam int CNT_W    = $clog2(TAPS + 1);
    localparam int KW       = $clog2(K + 1);
    localparam int POS_W    = $clog2(((IMG_W > IMG_H) ? IMG_W : IMG_H) + 1);
    localparam int OUT_W_S1 = IMG_W - K + 1;
    localparam int OUT_W_S2 = (IMG_W - K) / 2 + 1;
    localparam int OUT_H_S1 = IMG_H - K + 1;
    localparam int OUT_H_S2 = (IMG_H - K) / 2 + 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TAPS);
    localparam logic [KW-1:0]    K_LAST    = KW'(K - 1);
    localparam logic [POS_W-1:0] LAST_C_S1 = POS_W'(OUT_W_S1 - 1);
    localparam logic [POS_W-1:0] LAST_C_S2 = POS_W'(OUT_W_S2 - 1);
    localparam logic [POS_W-1:0] LAST_R_S1 = POS_W'(OUT_H_S1 - 1);
    localparam logic [POS_W-1:0] LAST_R_S2 = POS_W'(OUT_H_S2 - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q;
    logic [KW-1:0]            kr_q, kc_q;
    logic [POS_W-1:0]         r_q, c_q;
    logic                     stride2_q;
    logic [ADDR_W-1:0]        src_base_q, ker_base_q;
    logic signed [DATA_W-1:0] ker_q [TAPS];

    logic [CNT_W-1:0]         tap_idx;
    logic [POS_W-1:0]         last_c, last_r;
    logic                     last_win;
    logic                     mac_clr, mac_en;
    logic signed [ACC_W-1:0]  acc;
    logic [ADDR_W-1:0]        win_row, win_col;

    // Read data returns one cycle after its strobe, so tap cnt-1 is landing now.
    assign tap_idx  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;
    assign last_c   = stride2_q ? LAST_C_S2 : LAST_C_S1;
    assign last_r   = stride2_q ? LAST_R_S2 : LAST_R_S1;
    assign last_win = (c_q == last_c) && (r_q == last_r);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (i_start) state_d = LOAD_KER;
            LOAD_KER: if (cnt_q == CNT_LAST) state_d = LOAD_WIN;
            LOAD_WIN: if (cnt_q == CNT_LAST) state_d = EMIT;
            EMIT:     if (i_out_ready) state_d = last_win ? DONE : LOAD_WIN;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q      <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
            r_q        <= '0;
            c_q        <= '0;
            stride2_q  <= 1'b0;
            src_base_q <= '0;
            ker_base_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    kr_q  <= '0;
                    kc_q  <= '0;
                    r_q   <= '0;
                    c_q   <= '0;
                    if (i_start) begin
                        stride2_q  <= (i_stride == STRIDE_2);
                        src_base_q <= i_src_base;
                        ker_base_q <= i_ker_base;
                    end
                end
                LOAD_KER, LOAD_WIN: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        kr_q  <= '0;
                        kc_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (kc_q == K_LAST) begin
                            kc_q <= '0;
                            kr_q <= kr_q + 1'b1;
                        end else begin
                            kc_q <= kc_q + 1'b1;
                        end
                    end
                end
                EMIT: begin
                    if (i_out_ready) begin
                        if (c_q == last_c) begin
                            c_q <= '0;
                            r_q <= r_q + 1'b1;
                        end else begin
                            c_q <= c_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Kernel storage deliberately has no reset; it is reloaded on every start.
    always_ff @(posedge i_clk) begin
        if (state_q == LOAD_KER && cnt_q != '0) begin
            ker_q[tap_idx] <= i_ker_data;
        end
    end

    assign mac_clr = (state_q == LOAD_WIN) && (cnt_q == '0);
    assign mac_en  = (state_q == LOAD_WIN) && (cnt_q != '0);

    conv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (mac_clr),
        .i_en    (mac_en),
        .i_a     (i_src_data),
        .i_b     (ker_q[tap_idx]),
        .o_acc   (acc)
    );

    assign win_row = (stride2_q ? (ADDR_W'(r_q) << 1) : ADDR_W'(r_q)) + ADDR_W'(kr_q);
    assign win_col = (stride2_q ? (ADDR_W'(c_q) << 1) : ADDR_W'(c_q)) + ADDR_W'(kc_q);

    assign o_ker_rd   = (state_q == LOAD_KER) && (cnt_q != CNT_LAST);
    assign o_ker_addr = o_ker_rd ? ker_base_q + ADDR_W'(cnt_q) : '0;
    assign o_src_rd   = (state_q == LOAD_WIN) && (cnt_q != CNT_LAST);
    assign o_src_addr = o_src_rd ? src_base_q + win_row * ADDR_W'(IMG_W) + win_col : '0;

    // Result stream: a word transfers on a cycle with o_out_valid && i_out_ready;
    // once raised, valid and data hold unchanged until that transfer happens.
    assign o_out_valid = (state_q == EMIT);
`ifdef CONV_RELU_EN
    assign o_out_data  = acc[ACC_W-1] ? '0 : acc;
`else
    assign o_out_data  = acc;
`endif
    assign o_busy      = (state_q == LOAD_KER) || (state_q == LOAD_WIN) || (state_q == EMIT);
    assign o_done      = (state_q == DONE);
    assign o_dbg_state = state_q;

endmodule
